hazard_scoreboard: RTL and testbench

- Issue-control block between IDU and EXU in the in-order RISC-V pipeline.
- Tracks in-flight register writes in a per-register pending-count scoreboard and stalls issue on RAW hazards (no forwarding path).
- Converts a taken jump from EXU into a one-cycle flush of the wrong-path instruction in IDU.
- Keeps a stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 97 +++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard between IDU and EXU: per-register pending-write counters,
// issue gating, one-cycle jump flush and a stall-cycle performance counter.

module hsb_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             underflow
);
   assign underflow = dec & (cnt == '0);

   // inc and dec together cancel; a retire against an empty counter leaves it at 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          cnt <= '0;
      else if (inc & ~dec)               cnt <= cnt + 1'b1;
      else if (dec & ~inc & cnt != '0)   cnt <= cnt - 1'b1;
   end
endmodule

module hazard_scoreboard #(
   parameter int NR_REGS = 32,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_en,
   input  logic        id_rs2_en,
   input  logic [4:0]  id_rd,
   input  logic        id_regwr,
   input  logic        exu_ready,
   output logic        issue_valid,
   output logic        id_ready,
   input  logic        is_jump,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        wb_regwr,
   output logic        flush,
   output logic [31:0] stall_cnt,
   output logic        sb_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NR_REGS-1:0][CNT_W-1:0] cnt;
   logic [NR_REGS-1:0]            inc_vec, dec_vec, uflow;
   logic rs1_hit, rs2_hit, hazard, full, issue_fire, inc, dec, blocked;

   assign rs1_hit = id_rs1_en & (id_rs1 != '0) & (cnt[id_rs1] != '0);
   assign rs2_hit = id_rs2_en & (id_rs2 != '0) & (cnt[id_rs2] != '0);
   assign hazard  = rs1_hit | rs2_hit;
   assign full    = id_regwr & (id_rd != '0) & (cnt[id_rd] == CNT_MAX);

   assign issue_valid = id_valid & ~flush & ~hazard & ~full;
   assign issue_fire  = issue_valid & exu_ready;
   assign id_ready    = flush | issue_fire;
   assign blocked     = id_valid & ~flush & (hazard | full);

   assign inc = issue_fire & id_regwr & (id_rd != '0);
   assign dec = wb_valid & wb_regwr & (wb_rd != '0);

   // x0 has no counter and can never hazard
   assign cnt[0]     = '0;
   assign inc_vec[0] = 1'b0;
   assign dec_vec[0] = 1'b0;
   assign uflow[0]   = 1'b0;

   for (genvar r = 1; r < NR_REGS; r++) begin : g_reg
      assign inc_vec[r] = inc & (id_rd == 5'(r));
      assign dec_vec[r] = dec & (wb_rd == 5'(r));
      hsb_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_vec[r]),
         .dec       (dec_vec[r]),
         .cnt       (cnt[r]),
         .underflow (uflow[r])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush     <= 1'b0;
         stall_cnt <= '0;
         sb_err    <= 1'b0;
      end else begin
         flush  <= is_jump;
         sb_err <= sb_err | (|uflow);
         if (blocked) stall_cnt <= stall_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against an array-based model.

module tb_hazard_scoreboard;
   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs1_en, id_rs2_en, id_regwr, exu_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
   logic        is_jump, wb_valid, wb_regwr;
   logic        issue_valid, id_ready, flush, sb_err;
   logic [31:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   int          mcnt [32];
   bit          mflush, merr;
   logic [31:0] mstall;

   hazard_scoreboard #(.NR_REGS(32), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
      .id_rd(id_rd), .id_regwr(id_regwr), .exu_ready(exu_ready),
      .issue_valid(issue_valid), .id_ready(id_ready), .is_jump(is_jump),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
      .flush(flush), .stall_cnt(stall_cnt), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hazard();
      return (id_rs1_en && id_rs1 != 0 && mcnt[id_rs1] != 0) ||
             (id_rs2_en && id_rs2 != 0 && mcnt[id_rs2] != 0);
   endfunction
   function automatic bit m_full();
      return id_regwr && id_rd != 0 && mcnt[id_rd] == 3;
   endfunction
   function automatic bit m_iv();
      return id_valid && !mflush && !m_hazard() && !m_full();
   endfunction

   task automatic m_reset();
      foreach (mcnt[i]) mcnt[i] = 0;
      mflush = 0; merr = 0; mstall = 0;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
      id_rd = 0; id_regwr = 0; exu_ready = 1; is_jump = 0;
      wb_valid = 0; wb_rd = 0; wb_regwr = 0;
   endtask

   task automatic instr(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                        input int rd, input bit wr);
      id_valid = v; id_rs1 = 5'(rs1); id_rs1_en = e1; id_rs2 = 5'(rs2); id_rs2_en = e2;
      id_rd = 5'(rd); id_regwr = wr;
   endtask

   task automatic retire(input bit v, input int rd);
      wb_valid = v; wb_rd = 5'(rd); wb_regwr = v;
   endtask

   // compare all outputs against the model once inputs have settled
   task automatic settle();
      #1;
      check("issue_valid", issue_valid, m_iv());
      check("id_ready", id_ready, mflush || (m_iv() && exu_ready));
      check("flush", flush, mflush);
      check("stall_cnt", stall_cnt, mstall);
      check("sb_err", sb_err, merr);
   endtask

   task automatic adv();
      bit fire, inc, dec, blk;
      @(posedge clk);
      fire = m_iv() && exu_ready;
      inc  = fire && id_regwr && id_rd != 0;
      dec  = wb_valid && wb_regwr && wb_rd != 0;
      blk  = id_valid && !mflush && (m_hazard() || m_full());
      if (dec && mcnt[wb_rd] == 0) merr = 1;
      if (!(inc && dec && id_rd == wb_rd)) begin
         if (inc) mcnt[id_rd]++;
         if (dec && mcnt[wb_rd] > 0) mcnt[wb_rd]--;
      end
      if (blk) mstall++;
      mflush = is_jump;
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   initial begin
      int r;
      idle();
      rst = 0;
      m_reset();
      #12;
      settle();
      check("rst_flush", flush, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_issue_valid", issue_valid, 0);
      @(negedge clk);
      rst = 1;

      // RAW on x5: writer, then reader blocked until the cycle after retire
      instr(1, 0, 0, 0, 0, 5, 1); step();
      instr(1, 5, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin settle(); check("raw_block", issue_valid, 0); adv(); end
      retire(1, 5); settle(); check("raw_retire_cycle", issue_valid, 0); adv();
      retire(0, 0); settle(); check("raw_release", issue_valid, 1); check("raw_stalls", stall_cnt, 4); adv();

      // x0 writer then reader: no tracking, no stall
      instr(1, 0, 0, 0, 0, 0, 1); step();
      instr(1, 0, 1, 0, 1, 0, 0); settle(); check("x0_issue", issue_valid, 1); adv();
      check("x0_stalls", stall_cnt, 4);

      // simultaneous inc/dec on x7 keeps the count at 1
      instr(1, 0, 0, 0, 0, 7, 1); step();
      retire(1, 7); step();
      retire(0, 0); instr(1, 0, 0, 7, 1, 0, 0);
      settle(); check("sim_still_pending", issue_valid, 0); adv();
      retire(1, 7); step();
      retire(0, 0); settle(); check("sim_release", issue_valid, 1); check("sim_stalls", stall_cnt, 6); adv();

      // saturation on x3
      instr(1, 0, 0, 0, 0, 3, 1);
      for (int i = 0; i < 3; i++) step();
      settle(); check("sat_block", issue_valid, 0); adv();
      check("sat_stall", stall_cnt, 7);
      retire(1, 3); settle(); check("sat_retire_cycle", issue_valid, 0); adv();
      retire(0, 0); settle(); check("sat_release", issue_valid, 1); adv();
      instr(0, 0, 0, 0, 0, 0, 0);
      retire(1, 3); for (int i = 0; i < 3; i++) step();
      retire(0, 0);

      // jump flush drops the wrong-path writer of x10
      instr(1, 0, 0, 0, 0, 0, 0); is_jump = 1; step();
      is_jump = 0; instr(1, 0, 0, 0, 0, 10, 1);
      settle(); check("jmp_flush", flush, 1); check("jmp_ready", id_ready, 1); check("jmp_iv", issue_valid, 0); adv();
      instr(1, 10, 1, 0, 0, 0, 0);
      settle(); check("jmp_flush_gone", flush, 0); check("jmp_no_sb_change", issue_valid, 1); adv();

      // backpressure is not a hazard stall
      exu_ready = 0;
      settle(); check("bp_iv", issue_valid, 1); check("bp_ready", id_ready, 0); adv();
      check("bp_stall", stall_cnt, 8);
      exu_ready = 1; instr(0, 0, 0, 0, 0, 0, 0);

      // retire against empty counter is sticky
      retire(1, 9); step();
      retire(0, 0); check("err_set", sb_err, 1); step();
      check("err_sticky", sb_err, 1);

      // async reset mid-cycle with nonzero counts and flush pending
      instr(1, 0, 0, 0, 0, 12, 1); step();
      is_jump = 1; step();
      is_jump = 0; instr(1, 12, 1, 0, 0, 0, 0);
      settle(); check("pre_rst_flush", flush, 1);
      #2 rst = 0; m_reset();
      #1;
      check("arst_flush", flush, 0); check("arst_stall", stall_cnt, 0);
      check("arst_err", sb_err, 0); check("arst_cnt12", issue_valid, 1);
      @(negedge clk); rst = 1;
      settle();

      // randomized traffic over a small register set
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         idle();
         instr($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         exu_ready = $urandom_range(0, 5) != 0;
         if ($urandom_range(0, 2) != 0) begin
            for (int t = 0; t < 4; t++) begin
               r = $urandom_range(1, 7);
               if (mcnt[r] > 0) begin retire(1, r); break; end
            end
         end
         if (m_iv() && exu_ready && $urandom_range(0, 7) == 0) is_jump = 1;
         settle();
         @(posedge clk);
         #0;
         // reuse adv model update without double-waiting the edge
         begin
            bit fire, inc, dec, blk;
            fire = m_iv() && exu_ready;
            inc  = fire && id_regwr && id_rd != 0;
            dec  = wb_valid && wb_regwr && wb_rd != 0;
            blk  = id_valid && !mflush && (m_hazard() || m_full());
            if (dec && mcnt[wb_rd] == 0) merr = 1;
            if (!(inc && dec && id_rd == wb_rd)) begin
               if (inc) mcnt[id_rd]++;
               if (dec && mcnt[wb_rd] > 0) mcnt[wb_rd]--;
            end
            if (blk) mstall++;
            mflush = is_jump;
         end
      end
      @(negedge clk);
      idle();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
